// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive peripheral: register word
// offsets, STATUS bit positions and the state encodings of both FSMs.
package uart_pkg;

  // Register word index, taken from araddr[3:2]
  localparam logic [1:0] ADDR_RXDATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;

  // STATUS register bit positions
  localparam int unsigned ST_NEMPTY  = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVR     = 2;
  localparam int unsigned ST_FERR    = 3;
  localparam int unsigned ST_CNT_LSB = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic {
    AR_IDLE,
    R_RESP
  } ar_state_t;

endpackage

// File: rtl/uart_rx_axilite_if.sv
// AXI-Lite read-only channel bundle for the UART receive peripheral.
//   araddr/arvalid/arready : read address handshake
//   rdata/rvalid/rready    : read data handshake
interface uart_rx_axilite_if;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rvalid
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART deserialiser.
//   clk, rst_n : system clock, async active-low reset
//   rx         : serial input, idle high, asynchronous to clk
//   rx_data    : last assembled byte (valid when rx_done pulses)
//   rx_done    : 1-cycle pulse, good stop bit seen
//   rx_ferr    : 1-cycle pulse, stop bit sampled low (byte discarded)
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 12000000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_ferr
);

  localparam int unsigned BIT_PERIOD  = CLK_FREQ / BAUD;
  localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
  localparam logic [15:0] BIT_LAST    = 16'(BIT_PERIOD - 1);
  localparam logic [15:0] HALF_LAST   = 16'(HALF_PERIOD - 1);

  logic        rx_m, rx_s;
  rx_state_t   state, state_n;
  logic [15:0] clk_cnt, clk_cnt_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shift, shift_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      state   <= RX_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt + 16'd1;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    rx_done   = 1'b0;
    rx_ferr   = 1'b0;
    case (state)
      RX_IDLE: begin
        clk_cnt_n = '0;
        if (!rx_s) state_n = RX_START;
      end
      RX_START: begin
        // Re-check at mid start bit; a high line here was a glitch
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_n = '0;
          if (!rx_s) begin
            state_n   = RX_DATA;
            bit_cnt_n = '0;
          end else begin
            state_n = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n        = '0;
          shift_n[bit_cnt] = rx_s;
          bit_cnt_n        = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n = '0;
          if (rx_s) begin
            rx_done = 1'b1;
            state_n = RX_IDLE;
          end else begin
            rx_ferr = 1'b1;
            state_n = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // Holding here until the line rises keeps a break to one error
        clk_cnt_n = '0;
        if (rx_s) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign rx_data = shift;

endmodule

// File: rtl/uart_rx_axilite.sv
// UART receiver with a small byte FIFO and an AXI-Lite read slave.
//   clk, rst_n : system clock, async active-low reset
//   bus        : AXI-Lite read channel (slave modport)
//   rx         : UART serial input
//   rx_irq     : high while the receive FIFO holds data
// Registers (araddr[3:2]): 0 RXDATA {valid,byte} pops on read,
// 1 STATUS {count,frame_err,overrun,full,!empty} clears flags on read.
module uart_rx_axilite
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_rx_axilite_if.slave   bus,
  input  logic               rx,
  output logic               rx_irq
);

  localparam int unsigned   AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW       = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [7:0] rx_data;
  logic       rx_done, rx_ferr;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .rx_ferr (rx_ferr)
  );

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic          empty, full, push, pop, ovr_evt;
  logic          overrun, frame_err;

  ar_state_t     ar_state, ar_state_n;
  logic          accept, stat_rd;
  logic [1:0]    rd_sel;
  logic [31:0]   rd_word, status, rdata_q;
  logic          unused_addr;

  assign unused_addr = ^bus.araddr[1:0];
  assign rd_sel      = bus.araddr[3:2];
  assign accept      = (ar_state == AR_IDLE) && bus.arvalid;
  assign stat_rd     = accept && (rd_sel == ADDR_STATUS);

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = accept && (rd_sel == ADDR_RXDATA) && !empty;
  // A same-cycle pop frees the slot, so a full FIFO only overruns without one
  assign push    = rx_done && (!full || pop);
  assign ovr_evt = rx_done && full && !pop;

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rx_irq    <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_n;
      rx_irq    <= (count_n != '0);
      // Set events win over a clearing STATUS read in the same cycle
      overrun   <= (overrun   & ~stat_rd) | ovr_evt;
      frame_err <= (frame_err & ~stat_rd) | rx_ferr;
    end
  end

  always_comb begin
    status                      = '0;
    status[ST_CNT_LSB +: 4]     = 4'(count);
    status[ST_FERR]             = frame_err;
    status[ST_OVR]              = overrun;
    status[ST_FULL]             = full;
    status[ST_NEMPTY]           = !empty;
  end

  always_comb begin
    rd_word = '0;
    case (rd_sel)
      ADDR_RXDATA: rd_word = empty ? '0 : {23'b0, 1'b1, mem[rd_ptr]};
      ADDR_STATUS: rd_word = status;
      default:     rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_state <= AR_IDLE;
      rdata_q  <= '0;
    end else begin
      ar_state <= ar_state_n;
      if (accept) rdata_q <= rd_word;
    end
  end

  always_comb begin
    ar_state_n  = ar_state;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    case (ar_state)
      AR_IDLE: begin
        bus.arready = 1'b1;
        if (bus.arvalid) ar_state_n = R_RESP;
      end
      R_RESP: begin
        bus.rvalid = 1'b1;
        if (bus.rready) ar_state_n = AR_IDLE;
      end
      default: ar_state_n = AR_IDLE;
    endcase
  end

  assign bus.rdata = rdata_q;

endmodule
